// File: rtl/seg_scan_capture.sv
// Reads a time-multiplexed 7-segment bus back into a hex value. It settles on
// each digit enable, decodes the segments, assembles frames and commits a value once frames repeat.
module seg_scan_capture #(
   parameter int NUM_DIGITS = 4,
   parameter int SETTLE     = 2,
   parameter int FRAMES     = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    valid,
   output logic                    err,
   output logic [NUM_DIGITS-1:0]   err_mask
);

   localparam int          W        = 4 * NUM_DIGITS;
   localparam logic [3:0]  SETTLE_C = 4'(SETTLE);
   localparam logic [2:0]  FRAMES_C = 3'(FRAMES);

   logic [NUM_DIGITS-1:0] prev_an;
   logic [3:0]            dwell;
   logic [3:0]            dwell_next;
   logic [NUM_DIGITS-1:0] mask;
   logic [NUM_DIGITS-1:0] mask_next;
   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] bad;
   logic [W-1:0]          prev_frame;
   logic [2:0]            match;
   logic                  committed;

   logic                  one_hot;
   logic                  multi_hot;
   logic                  same_an;
   logic                  sample;
   logic [3:0]            dec_nib;
   logic                  dec_bad;
   logic                  frame_full;
   logic                  frame_bad;
   logic [W-1:0]          frame_word;
   logic [2:0]            match_new;
   logic                  commit;

   always_comb begin
      dec_bad = 1'b0;
      dec_nib = 4'h0;
      case (seg)
         7'b0111111: dec_nib = 4'h0;
         7'b0000110: dec_nib = 4'h1;
         7'b1011011: dec_nib = 4'h2;
         7'b1001111: dec_nib = 4'h3;
         7'b1100110: dec_nib = 4'h4;
         7'b1101101: dec_nib = 4'h5;
         7'b1111101: dec_nib = 4'h6;
         7'b0000111: dec_nib = 4'h7;
         7'b1111111: dec_nib = 4'h8;
         7'b1101111: dec_nib = 4'h9;
         7'b1110111: dec_nib = 4'hA;
         7'b1111100: dec_nib = 4'hB;
         7'b0111001: dec_nib = 4'hC;
         7'b1011110: dec_nib = 4'hD;
         7'b1111001: dec_nib = 4'hE;
         7'b1110001: dec_nib = 4'hF;
         default:    dec_bad = 1'b1;
      endcase
   end

   // A dwell restarts at 1 on a new one-hot enable; the sample fires once, on the
   // cycle the count first reaches SETTLE, even if the counter later saturates there.
   always_comb begin
      one_hot    = (an != '0) && ((an & (an - NUM_DIGITS'(1))) == '0);
      multi_hot  = (an != '0) && !one_hot;
      same_an    = (an == prev_an);
      dwell_next = 4'd0;
      if (one_hot) begin
         if (same_an) begin
            dwell_next = (dwell == 4'd15) ? 4'd15 : dwell + 4'd1;
         end else begin
            dwell_next = 4'd1;
         end
      end
      sample = one_hot && (dwell_next == SETTLE_C) && (!same_an || (dwell != SETTLE_C));
   end

   // A full mask is consumed on the following edge, so a sample landing on that
   // same edge starts the next frame instead of being lost.
   always_comb begin
      frame_full = &mask;
      frame_bad  = |bad;
      frame_word = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         frame_word[4*i +: 4] = nib[i];
      end
      mask_next = frame_full ? '0 : mask;
      if (sample) begin
         mask_next = mask_next | an;
      end
      if (multi_hot) begin
         mask_next = '0;
      end
      if (frame_word == prev_frame) begin
         match_new = (match >= FRAMES_C) ? FRAMES_C : match + 3'd1;
      end else begin
         match_new = 3'd1;
      end
      commit = frame_full && !frame_bad && (match_new == FRAMES_C)
               && ((frame_word != value) || !committed);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_an    <= '0;
         dwell      <= 4'd0;
         mask       <= '0;
         bad        <= '0;
         prev_frame <= '0;
         match      <= 3'd0;
         committed  <= 1'b0;
         value      <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         err_mask   <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] <= 4'h0;
         end
      end else begin
         valid   <= 1'b0;
         err     <= 1'b0;
         prev_an <= an;
         dwell   <= dwell_next;
         mask    <= mask_next;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sample && an[i]) begin
               nib[i] <= dec_nib;
               bad[i] <= dec_bad;
            end
         end
         if (frame_full) begin
            if (frame_bad) begin
               err      <= 1'b1;
               err_mask <= bad;
               match    <= 3'd0;
            end else begin
               prev_frame <= frame_word;
               match      <= match_new;
               if (commit) begin
                  value     <= frame_word;
                  valid     <= 1'b1;
                  committed <= 1'b1;
               end
            end
         end
         // A multi-hot glitch invalidates any partial agreement between frames.
         if (multi_hot) begin
            match <= 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans hand-built frames and checks the
// committed value, the valid/err pulse counts and err_mask after each scenario.
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] value;
   logic        valid;
   logic        err;
   logic [3:0]  err_mask;

   int checks = 0;
   int passes = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int double_cnt = 0;
   logic prev_valid = 1'b0;
   int valid_base;
   int err_base;

   seg_scan_capture #(.NUM_DIGITS(4), .SETTLE(2), .FRAMES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .seg      (seg),
      .an       (an),
      .value    (value),
      .valid    (valid),
      .err      (err),
      .err_mask (err_mask)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) valid_cnt++;
      if (err) err_cnt++;
      if (valid && err) both_cnt++;
      if (valid && prev_valid) double_cnt++;
      prev_valid = valid;
   end

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic hold(input logic [3:0] an_v, input logic [6:0] seg_v, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         an  = an_v;
         seg = seg_v;
      end
   endtask

   // One digit per dwell, digit 0 first; dwell[i]=0 skips a digit, then one blank cycle.
   task automatic scan_raw(input logic [27:0] pats, input logic [15:0] dwells);
      for (int d = 0; d < 4; d++) begin
         if (dwells[4*d +: 4] != 4'd0) begin
            hold(4'(1 << d), pats[7*d +: 7], int'(dwells[4*d +: 4]));
         end
         hold(4'b0000, 7'b0000000, 1);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] word);
      scan_raw({enc(word[15:12]), enc(word[11:8]), enc(word[7:4]), enc(word[3:0])}, 16'h4444);
   endtask

   task automatic mark();
      valid_base = valid_cnt;
      err_base   = err_cnt;
   endtask

   initial begin
      reset = 1'b1;
      an    = 4'b0000;
      seg   = 7'b0000000;
      hold(4'b0000, 7'b0000000, 3);
      @(negedge clk);
      reset = 1'b0;
      check_output("reset_value", 32'(value), 32'h0);
      check_output("reset_valid", 32'(valid), 32'h0);
      check_output("reset_err", 32'(err), 32'h0);
      check_output("reset_err_mask", 32'(err_mask), 32'h0);

      $display("[TB] scan 1A3F");
      mark();
      apply_stimulus(16'h1A3F);
      check_output("one_frame_no_valid", 32'(valid_cnt - valid_base), 32'd0);
      apply_stimulus(16'h1A3F);
      hold(4'b0000, 7'b0000000, 2);
      check_output("commit_value", 32'(value), 32'h1A3F);
      check_output("commit_valid_count", 32'(valid_cnt - valid_base), 32'd1);
      check_output("commit_err_count", 32'(err_cnt - err_base), 32'd0);
      check_output("valid_single_cycle", 32'(double_cnt), 32'd0);

      $display("[TB] repeat 1A3F");
      mark();
      for (int f = 0; f < 3; f++) apply_stimulus(16'h1A3F);
      hold(4'b0000, 7'b0000000, 2);
      check_output("repeat_no_valid", 32'(valid_cnt - valid_base), 32'd0);
      check_output("repeat_value", 32'(value), 32'h1A3F);

      $display("[TB] bad digit 2");
      mark();
      scan_raw({enc(4'h1), 7'b0000001, enc(4'h3), enc(4'hF)}, 16'h4444);
      hold(4'b0000, 7'b0000000, 2);
      check_output("bad_err_count", 32'(err_cnt - err_base), 32'd1);
      check_output("bad_err_mask", 32'(err_mask), 32'h4);
      check_output("bad_value_kept", 32'(value), 32'h1A3F);
      check_output("bad_no_valid", 32'(valid_cnt - valid_base), 32'd0);
      mark();
      apply_stimulus(16'h2222);
      apply_stimulus(16'h2222);
      hold(4'b0000, 7'b0000000, 2);
      check_output("recover_valid_count", 32'(valid_cnt - valid_base), 32'd1);
      check_output("recover_value", 32'(value), 32'h2222);
      check_output("recover_err_count", 32'(err_cnt - err_base), 32'd0);
      check_output("err_mask_held", 32'(err_mask), 32'h4);

      $display("[TB] short dwell on digit 1");
      mark();
      for (int f = 0; f < 3; f++) begin
         scan_raw({enc(4'h5), enc(4'h5), enc(4'h5), enc(4'h5)}, 16'h4414);
      end
      hold(4'b0000, 7'b0000000, 2);
      check_output("short_no_valid", 32'(valid_cnt - valid_base), 32'd0);
      check_output("short_no_err", 32'(err_cnt - err_base), 32'd0);
      check_output("short_value", 32'(value), 32'h2222);

      $display("[TB] multi-hot discard then BEEF");
      apply_stimulus(16'hBEEF);
      scan_raw({enc(4'hB), enc(4'hE), enc(4'hE), enc(4'hF)}, 16'h0044);
      hold(4'b0011, enc(4'h8), 3);
      hold(4'b0000, 7'b0000000, 1);
      mark();
      apply_stimulus(16'hBEEF);
      check_output("beef_first_no_valid", 32'(valid_cnt - valid_base), 32'd0);
      apply_stimulus(16'hBEEF);
      hold(4'b0000, 7'b0000000, 2);
      check_output("beef_valid_count", 32'(valid_cnt - valid_base), 32'd1);
      check_output("beef_value", 32'(value), 32'hBEEF);
      check_output("beef_no_err", 32'(err_cnt - err_base), 32'd0);

      $display("[TB] reset between frames of 8008");
      apply_stimulus(16'h8008);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("mid_reset_value", 32'(value), 32'h0);
      mark();
      apply_stimulus(16'h8008);
      check_output("post_reset_one_frame", 32'(valid_cnt - valid_base), 32'd0);
      apply_stimulus(16'h8008);
      hold(4'b0000, 7'b0000000, 2);
      check_output("post_reset_valid_count", 32'(valid_cnt - valid_base), 32'd1);
      check_output("post_reset_value", 32'(value), 32'h8008);

      $display("[TB] minimum dwell of SETTLE cycles");
      mark();
      for (int f = 0; f < 2; f++) begin
         scan_raw({enc(4'h0), enc(4'h7), enc(4'hC), enc(4'hD)}, 16'h2222);
      end
      hold(4'b0000, 7'b0000000, 2);
      check_output("settle_valid_count", 32'(valid_cnt - valid_base), 32'd1);
      check_output("settle_value", 32'(value), 32'h07CD);
      check_output("valid_err_exclusive", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
